// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux with programmable dwell per grant.
// Define MUX_SEL_FIXED_PRIO_EN for fixed priority (channel 0 highest).
module mux_sel_arbiter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    output logic               s0,
    output logic               s1,
    output logic [3:0]         grant,
    output logic               grant_valid,
    output logic               grant_done
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             r_state;
    logic [1:0]         r_chan;
    logic [1:0]         r_sel;
    logic [3:0]         r_grant;
    logic               r_valid;
    logic               r_done;
    logic [DWELL_W-1:0] r_len;
    logic [DWELL_W-1:0] r_cnt;

    logic               w_end;
    logic               w_issue;
    logic [1:0]         w_pick;
    logic [DWELL_W-1:0] w_len;

`ifdef MUX_SEL_FIXED_PRIO_EN
    function automatic logic [1:0] f_pick(input logic [3:0] r);
        logic [1:0] sel;
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) sel = 2'(i);
        end
        return sel;
    endfunction
`else
    logic [1:0] r_ptr;

    // Search starts just after the last winner, so the previous owner is checked last.
    function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] sel;
        logic [1:0] idx;
        logic       hit;
        sel = p;
        hit = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = p + 2'(i);
            if (!hit && r[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
        return sel;
    endfunction
`endif

    always_comb begin
        w_end   = (r_state == HOLD) &&
                  ((r_cnt == r_len - DWELL_W'(1)) || !req[r_chan]);
        w_issue = en && (|req) && ((r_state == IDLE) || w_end);
        w_len   = (dwell == '0) ? DWELL_W'(1) : dwell;
`ifdef MUX_SEL_FIXED_PRIO_EN
        w_pick  = f_pick(req);
`else
        w_pick  = f_pick(req, r_ptr);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_chan  <= 2'd0;
            r_sel   <= 2'd0;
            r_grant <= 4'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_len   <= DWELL_W'(1);
            r_cnt   <= '0;
`ifndef MUX_SEL_FIXED_PRIO_EN
            r_ptr   <= 2'd3;
`endif
        end else begin
            r_done <= w_end;
            if (w_issue) begin
                r_state <= HOLD;
                r_chan  <= w_pick;
                r_sel   <= w_pick;
                r_grant <= 4'b0001 << w_pick;
                r_valid <= 1'b1;
                r_len   <= w_len;
                r_cnt   <= '0;
`ifndef MUX_SEL_FIXED_PRIO_EN
                r_ptr   <= w_pick;
`endif
            end else if (w_end) begin
                // Select lines hold their last value so the mux output stays put.
                r_state <= IDLE;
                r_grant <= 4'd0;
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == HOLD) begin
                r_cnt <= r_cnt + DWELL_W'(1);
            end
        end
    end

    assign s0          = r_sel[0];
    assign s1          = r_sel[1];
    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_done  = r_done;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] dwell = 4'd1;
    logic       s0, s1;
    logic [3:0] grant;
    logic       grant_valid;
    logic       grant_done;

    int checks = 0;
    int failures = 0;

    // Reference model: owner, remaining cycles, last winner.
    int m_busy, m_ch, m_rem, m_ptr, m_sel, m_done;

    mux_sel_arbiter #(.DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .dwell(dwell),
        .s0(s0), .s1(s1), .grant(grant),
        .grant_valid(grant_valid), .grant_done(grant_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_ch = 0; m_rem = 0; m_ptr = 3; m_sel = 0; m_done = 0;
    endtask

    function automatic int search(input logic [3:0] r, input int p);
        int ch;
        ch = -1;
`ifdef MUX_SEL_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) if (r[i]) ch = i;
`else
        for (int i = 4; i >= 1; i--) if (r[(p + i) % 4]) ch = (p + i) % 4;
`endif
        return ch;
    endfunction

    task automatic model_edge();
        int fin;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fin = (m_busy != 0) && (m_rem == 1 || req[m_ch] == 1'b0);
        m_done = fin;
        if ((m_busy == 0 || fin) && en && req != 4'd0) begin
            m_ch = search(req, m_ptr);
            m_ptr = m_ch;
            m_sel = m_ch;
            m_busy = 1;
            m_rem = (dwell == 4'd0) ? 1 : int'(dwell);
        end else if (fin) begin
            m_busy = 0;
        end else if (m_busy != 0) begin
            m_rem = m_rem - 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        req = 4'd0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({s1, s0, grant, grant_valid, grant_done} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {s1, s0, grant, grant_valid, grant_done});
        end
    endtask

    task automatic test_single();
        int len;
        int dones;
        req = 4'b0100; dwell = 4'd3; en = 1'b1;
        step();
        en = 1'b0;
        checks++;
        if (grant !== 4'b0100 || {s1, s0} !== 2'b10) begin
            failures++;
            $display("FAIL single_grant got=%b/%b exp=0100/10", grant, {s1, s0});
        end
        len = 0; dones = 0;
        while (grant_valid && len < 40) begin
            len++;
            step();
            dones += grant_done;
        end
        step();
        dones += grant_done;
        checks++;
        if (len != 3 || dones != 1) begin
            failures++;
            $display("FAIL single_len got=%0d/%0d exp=3/1", len, dones);
        end
        checks++;
        if ({s1, s0} !== 2'b10 || grant !== 4'd0) begin
            failures++;
            $display("FAIL single_idle_sel got=%b/%b exp=10/0000", {s1, s0}, grant);
        end
    endtask

    task automatic test_round_robin();
        int exp_ch;
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111; dwell = 4'd2; en = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
`ifdef MUX_SEL_FIXED_PRIO_EN
            exp_ch = 0;
`else
            exp_ch = (k / 2) % 4;
`endif
            exp_g = 4'b0001 << exp_ch;
            checks++;
            if (grant !== exp_g || grant_valid !== 1'b1 ||
                int'({s1, s0}) != exp_ch) begin
                failures++;
                $display("FAIL rr_grant cyc=%0d got=%b exp=%b", k, grant, exp_g);
            end
            checks++;
            if (grant_done !== ((k > 0 && k % 2 == 0) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL rr_done cyc=%0d got=%b", k, grant_done);
            end
            step();
        end
        en = 1'b0;
        req = 4'd0;
        step();
        step();
    endtask

    task automatic test_early_release();
        int len;
        do_reset();
        req = 4'b0010; dwell = 4'd8; en = 1'b1;
        step();
        len = 1;
        step(); len++;
        step(); len++;
        req = 4'b0000;
        step();
        checks++;
        if (grant_valid !== 1'b0 || grant_done !== 1'b1 || len != 3) begin
            failures++;
            $display("FAIL early_release got=%b/%b len=%0d exp=0/1 len=3",
                     grant_valid, grant_done, len);
        end
    endtask

    task automatic run_grant(input logic [3:0] d, input logic [3:0] d_mid,
                             output int len, output int done_seen);
        req = 4'b1000; dwell = d; en = 1'b1;
        step();
        en = 1'b0;
        dwell = d_mid;
        len = 0;
        while (grant_valid && len < 40) begin
            len++;
            step();
        end
        done_seen = grant_done;
        req = 4'd0;
        step();
    endtask

    task automatic test_dwell_edges();
        int len, dn;
        run_grant(4'd0, 4'd0, len, dn);
        checks++;
        if (len != 1 || dn != 1) begin
            failures++;
            $display("FAIL dwell0 got=%0d/%0d exp=1/1", len, dn);
        end
        run_grant(4'd15, 4'd15, len, dn);
        checks++;
        if (len != 15 || dn != 1) begin
            failures++;
            $display("FAIL dwell15 got=%0d/%0d exp=15/1", len, dn);
        end
        run_grant(4'd3, 4'd9, len, dn);
        checks++;
        if (len != 3 || dn != 1) begin
            failures++;
            $display("FAIL dwell_change got=%0d/%0d exp=3/1", len, dn);
        end
    endtask

    task automatic test_en_drop();
        int len;
        int extra;
        req = 4'b1111; dwell = 4'd4; en = 1'b1;
        step();
        en = 1'b0;
        len = 0;
        while (grant_valid && len < 40) begin
            len++;
            step();
        end
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            extra += grant_valid;
        end
        checks++;
        if (len != 4 || extra != 0) begin
            failures++;
            $display("FAIL en_drop got=%0d/%0d exp=4/0", len, extra);
        end
        req = 4'd0;
    endtask

    task automatic test_reset_mid();
        req = 4'b0100; dwell = 4'd6; en = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({s1, s0, grant, grant_valid, grant_done} !== 8'd0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=0",
                     {s1, s0, grant, grant_valid, grant_done});
        end
        req = 4'b1111;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001 || grant_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_regrant got=%b/%b exp=0001/0", grant, grant_done);
        end
        en = 1'b0;
        req = 4'd0;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        do_reset();
        dwell = 4'd3;
        for (int k = 0; k < 600; k++) begin
            en = ($urandom % 8) != 0;
            if ($urandom % 3 == 0) req = 4'($urandom);
            if ($urandom % 5 == 0) dwell = 4'($urandom);
            step();
            exp_g = (m_busy != 0) ? (4'b0001 << m_ch) : 4'd0;
            checks++;
            if (grant !== exp_g || grant_valid !== (m_busy != 0)) begin
                failures++;
                $display("FAIL rand_grant cyc=%0d got=%b/%b exp=%b/%0d",
                         k, grant, grant_valid, exp_g, m_busy);
            end
            checks++;
            if (int'({s1, s0}) != m_sel || grant_done !== (m_done != 0)) begin
                failures++;
                $display("FAIL rand_sel_done cyc=%0d got=%b/%b exp=%0d/%0d",
                         k, {s1, s0}, grant_done, m_sel, m_done);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_dwell_edges();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
